// File: rtl/booth_seq_ctrl.sv
// Iterative radix-4 Booth 16x16 multiplier controller: one Booth row per cycle into a 32-bit accumulator.
// Optional BOOTH_EARLY_DONE_EN: finish as soon as every remaining multiplier digit is zero.
module booth_seq_ctrl #(
  parameter int unsigned SIGNED_B = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] product,
  output logic        busy
);

  localparam int unsigned AW     = 16;
  localparam int unsigned PW     = 32;
  localparam int unsigned RW     = AW + 1;
  localparam int unsigned EW     = 19;
  localparam int unsigned KW     = 4;
  localparam int unsigned LAST_K = (SIGNED_B != 0) ? 7 : 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   a_q, a_d;
  logic [EW-1:0]   b_ext_q, b_ext_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [KW-1:0]   k_q, k_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [4:0]      shamt;
  logic [2:0]      trip;
  logic [RW-1:0]   row;
  logic            neg;
  logic [PW-1:0]   term;
  logic            last_digit;
`ifdef BOOTH_EARLY_DONE_EN
  logic [EW-1:0]   rest;
  logic [EW-1:0]   ones;
`endif

  // Booth row generator for digit k plus the shifted accumulator term
  always_comb begin
    shamt = {k_q, 1'b0};
    trip  = b_ext_q[shamt +: 3];
    unique case (trip)
      3'b001, 3'b010: row = {a_q[AW-1], a_q};
      3'b011:         row = {a_q, 1'b0};
      3'b100:         row = ~{a_q, 1'b0};
      3'b101, 3'b110: row = ~{a_q[AW-1], a_q};
      default:        row = '0;
    endcase
    neg        = trip[2] & ~(trip[1] & trip[0]);
    term       = ({{(PW-RW){row[RW-1]}}, row} + PW'(neg)) << shamt;
    last_digit = (k_q == KW'(LAST_K));
`ifdef BOOTH_EARLY_DONE_EN
    // Uniform upper multiplier bits mean every later digit is zero
    rest = b_ext_q >> (shamt + 5'd2);
    ones = {EW{1'b1}} >> (shamt + 5'd2);
    if ((rest == '0) || (rest == ones)) begin
      last_digit = 1'b1;
    end
`endif
  end

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_ext_d = b_ext_q;
    acc_d   = acc_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_ext_d = (SIGNED_B != 0) ? {{2{b[15]}}, b, 1'b0} : {2'b00, b, 1'b0};
          acc_d   = '0;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_q + term;
        if (last_digit) begin
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_ext_q     <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_ext_q     <= b_ext_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = acc_q;

endmodule
